// File: rtl/smart_cargo_painel_tx.sv
// smart_cargo_painel_tx: panel-side 8N1 serial transmitter for the SmartCargo elevator.
// Requests are buffered in a small FIFO. Control pulses accumulate into pending bits and
// win the next frame boundary.
// Optional feature macro: SMART_CARGO_TX_INTERVALO_EN adds a post-stop idle bit (INTERVALO).
module smart_cargo_painel_tx #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       envia_pedido,
    input  logic [1:0] origem,
    input  logic [1:0] destino,
    input  logic [1:0] tipo,
    input  logic       iniciar,
    input  logic       reset_remoto,
    input  logic       emergencia,
    output logic       TX,
    output logic       ocupado,
    output logic       fila_cheia,
    output logic       fila_vazia,
    output logic       pedido_descartado,
    output logic [3:0] db_estado
);

    localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [PTR_W:0]    CNT_FULL  = (PTR_W + 1)'(FIFO_DEPTH);

`ifdef SMART_CARGO_TX_INTERVALO_EN
    typedef enum logic [3:0] {
        StOcioso    = 4'd0,
        StCarrega   = 4'd1,
        StStart     = 4'd2,
        StDados     = 4'd3,
        StStop      = 4'd4,
        StIntervalo = 4'd5
    } state_e;
`else
    typedef enum logic [3:0] {
        StOcioso  = 4'd0,
        StCarrega = 4'd1,
        StStart   = 4'd2,
        StDados   = 4'd3,
        StStop    = 4'd4
    } state_e;
`endif

    state_e            r_state, w_state_d;
    logic [BAUD_W-1:0] r_baud, w_baud_d;
    logic [2:0]        r_bit, w_bit_d;
    logic [7:0]        r_shift, w_shift_d;
    logic              r_sel_ctrl, w_sel_ctrl_d;
    logic              r_tx, w_tx_d;
    logic [2:0]        r_pend;       // {emergencia, reset_remoto, iniciar}
    logic              r_descartado;

    logic [5:0]        r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
    logic [PTR_W:0]    r_count;

    logic w_valid, w_full, w_empty, w_push, w_pop, w_load_ctrl;

    assign w_full      = (r_count == CNT_FULL);
    assign w_empty     = (r_count == '0);
    assign w_valid     = (tipo != 2'b00) && (origem != destino);
    // The selection latched in OCIOSO guarantees a non-empty FIFO when popping here
    assign w_pop       = (r_state == StCarrega) && !r_sel_ctrl;
    assign w_load_ctrl = (r_state == StCarrega) && r_sel_ctrl;
    // A full FIFO still accepts a request when the head leaves in the same cycle
    assign w_push      = envia_pedido && w_valid && (!w_full || w_pop);

    // FIFO storage, no reset needed: occupancy is tracked by the pointers
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {tipo, destino, origem};
        end
    end

    // FIFO pointers, occupancy, rejection pulse and pending control bits
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_descartado <= 1'b0;
            r_pend       <= 3'b000;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + (PTR_W + 1)'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - (PTR_W + 1)'(1);
            end
            r_descartado <= envia_pedido && !w_push;
            // Pulses landing on the load cycle survive for the following frame
            r_pend <= (w_load_ctrl ? 3'b000 : r_pend) | {emergencia, reset_remoto, iniciar};
        end
    end

    // FSM state and datapath registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= StOcioso;
            r_baud     <= '0;
            r_bit      <= 3'd0;
            r_shift    <= 8'h00;
            r_sel_ctrl <= 1'b0;
            r_tx       <= 1'b1;
        end else begin
            r_state    <= w_state_d;
            r_baud     <= w_baud_d;
            r_bit      <= w_bit_d;
            r_shift    <= w_shift_d;
            r_sel_ctrl <= w_sel_ctrl_d;
            r_tx       <= w_tx_d;
        end
    end

    // Next-state logic; TX is computed from the next state so the line is registered
    always_comb begin
        w_state_d    = r_state;
        w_baud_d     = r_baud + BAUD_W'(1);
        w_bit_d      = r_bit;
        w_shift_d    = r_shift;
        w_sel_ctrl_d = r_sel_ctrl;
        w_tx_d       = 1'b1;
        case (r_state)
            StOcioso: begin
                w_baud_d = '0;
                if (r_pend != 3'b000) begin
                    w_sel_ctrl_d = 1'b1;
                    w_state_d    = StCarrega;
                end else if (!w_empty) begin
                    w_sel_ctrl_d = 1'b0;
                    w_state_d    = StCarrega;
                end
            end
            StCarrega: begin
                w_baud_d  = '0;
                w_bit_d   = 3'd0;
                w_shift_d = r_sel_ctrl
                          ? {1'b1, 2'b00, r_pend[2], 1'b0, r_pend[1], 1'b0, r_pend[0]}
                          : {2'b00, r_mem[r_rd_ptr]};
                w_state_d = StStart;
            end
            StStart: begin
                if (r_baud == BAUD_LAST) begin
                    w_baud_d  = '0;
                    w_state_d = StDados;
                end
            end
            StDados: begin
                if (r_baud == BAUD_LAST) begin
                    w_baud_d = '0;
                    w_bit_d  = r_bit + 3'd1;
                    if (r_bit == 3'd7) begin
                        w_state_d = StStop;
                    end else begin
                        w_shift_d = {1'b0, r_shift[7:1]};
                    end
                end
            end
            StStop: begin
                if (r_baud == BAUD_LAST) begin
                    w_baud_d  = '0;
`ifdef SMART_CARGO_TX_INTERVALO_EN
                    w_state_d = StIntervalo;
`else
                    w_state_d = StOcioso;
`endif
                end
            end
`ifdef SMART_CARGO_TX_INTERVALO_EN
            StIntervalo: begin
                if (r_baud == BAUD_LAST) begin
                    w_baud_d  = '0;
                    w_state_d = StOcioso;
                end
            end
`endif
            default: begin
                w_baud_d  = '0;
                w_state_d = StOcioso;
            end
        endcase
        if (w_state_d == StStart) begin
            w_tx_d = 1'b0;
        end else if (w_state_d == StDados) begin
            w_tx_d = w_shift_d[0];
        end
    end

    assign TX                = r_tx;
    assign ocupado           = (r_state != StOcioso);
    assign fila_cheia        = w_full;
    assign fila_vazia        = w_empty;
    assign pedido_descartado = r_descartado;
    assign db_estado         = r_state;

endmodule
